avalon_st_timing_adapter_lat: RTL

Parametrised Avalon-ST timing adapter, successor to the fixed 32-bit/2-channel/6-error adapter, placed between a streaming source and sink whose ready latencies differ. Buffers full beats (data, channel, error, SOP, EOP) in a show-ahead FIFO. Generates a latency-aware `in_ready` so a compliant source never overflows. Drives `out_valid` under the sink's ready-latency rule, and latches a sticky overflow flag if a non-compliant source pushes into a full buffer.

---
 rtl/avalon_st_pkg.sv | 14 +
 rtl/avalon_st_sc_fifo_param.sv | 70 +++++++
 rtl/avalon_st_timing_adapter_lat.sv | 120 ++++++++++++
 3 files changed

// File: rtl/avalon_st_pkg.sv
// rtl/avalon_st_pkg.sv - shared constants and helpers for the Avalon-ST timing adapter
//
// Contents:
//   MAX_READY_LATENCY : largest ready latency either side of the adapter supports
//   payload_w()       : packed beat width {data, channel, error, sop, eop}
package avalon_st_pkg;

   localparam int MAX_READY_LATENCY = 3;

   function automatic int payload_w(input int data_w, input int ch_w, input int err_w);
      return data_w + ch_w + err_w + 2;
   endfunction

endpackage

// File: rtl/avalon_st_sc_fifo_param.sv
// rtl/avalon_st_sc_fifo_param.sv - show-ahead single-clock FIFO with occupancy counter
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (pointers and fill only)
//   push, wdata  : write request and beat; ignored when full unless popping too
//   pop          : consume head entry; ignored when empty
//   rdata        : head entry, valid whenever !empty (show-ahead)
//   fill         : occupancy 0..DEPTH
//   empty, full  : occupancy flags
module avalon_st_sc_fifo_param #(
   parameter int WIDTH = 42,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [FW-1:0]    fill_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (fill_q == '0);
   assign full    = (fill_q == FW'(DEPTH));
   assign do_pop  = pop && !empty;
   // At full a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
   assign do_push = push && (!full || do_pop);

   assign rdata = mem[rd_ptr];
   assign fill  = fill_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   fill_q <= fill_q + FW'(1);
            2'b01:   fill_q <= fill_q - FW'(1);
            default: fill_q <= fill_q;
         endcase
      end
   end

endmodule

// File: rtl/avalon_st_timing_adapter_lat.sv
// rtl/avalon_st_timing_adapter_lat.sv - Avalon-ST adapter bridging differing source/sink ready latencies
//
// Ports:
//   clk, reset_n          : sole clock, asynchronous active-low reset
//   in_ready              : registered grant, high while fill < DEPTH - IN_READY_LATENCY
//   in_valid, in_*        : source beat (data, channel, error, sop, eop)
//   out_ready             : sink grant (delayed OUT_READY_LATENCY cycles when nonzero)
//   out_valid, out_*      : head beat of the buffer
//   fill_level            : buffer occupancy 0..DEPTH
//   overflow              : sticky, set when a beat arrives at a full buffer with no pop
module avalon_st_timing_adapter_lat
   import avalon_st_pkg::*;
#(
   parameter int DATA_W            = 32,
   parameter int CHANNEL_W         = 2,
   parameter int ERROR_W           = 6,
   parameter int IN_READY_LATENCY  = 0,
   parameter int OUT_READY_LATENCY = 0,
   parameter int DEPTH             = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [CHANNEL_W-1:0]     in_channel,
   input  logic [ERROR_W-1:0]       in_error,
   input  logic                     in_startofpacket,
   input  logic                     in_endofpacket,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [CHANNEL_W-1:0]     out_channel,
   output logic [ERROR_W-1:0]       out_error,
   output logic                     out_startofpacket,
   output logic                     out_endofpacket,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     overflow
);

   localparam int PW = payload_w(DATA_W, CHANNEL_W, ERROR_W);
   localparam int FW = $clog2(DEPTH) + 1;
   // Leave room for the beats the source may still send on grants already issued.
   localparam logic [FW-1:0] RDY_LIMIT = FW'(DEPTH - IN_READY_LATENCY);

   logic          in_ready_q;
   logic          overflow_q;
   logic          push_req;
   logic          accept;
   logic          pop;
   logic          out_valid_int;
   logic          fifo_empty;
   logic          fifo_full;
   logic [FW-1:0] fill;
   logic [FW-1:0] fill_next;
   logic [PW-1:0] wdata;
   logic [PW-1:0] rdata;

   // With a nonzero latency the source only drives valid on cycles it was granted.
   assign push_req = (IN_READY_LATENCY == 0) ? (in_valid && in_ready_q) : in_valid;
   assign accept   = push_req && (!fifo_full || pop);
   assign fill_next = fill + FW'(accept) - FW'(pop);

   assign wdata = {in_data, in_channel, in_error, in_startofpacket, in_endofpacket};
   assign {out_data, out_channel, out_error, out_startofpacket, out_endofpacket} = rdata;

   generate
      if (OUT_READY_LATENCY == 0) begin : g_out_m0
         assign out_valid_int = !fifo_empty;
         assign pop           = out_valid_int && out_ready;
      end else begin : g_out_mn
         logic [OUT_READY_LATENCY-1:0] rdy_hist;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rdy_hist <= '0;
            end else begin
               rdy_hist <= (rdy_hist << 1) | OUT_READY_LATENCY'(out_ready);
            end
         end

         // The sink committed to accept M cycles ago, so presenting is popping.
         assign out_valid_int = !fifo_empty && rdy_hist[OUT_READY_LATENCY-1];
         assign pop           = out_valid_int;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_ready_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         in_ready_q <= (fill_next < RDY_LIMIT);
         if (push_req && fifo_full && !pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   avalon_st_sc_fifo_param #(
      .WIDTH (PW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_req),
      .pop     (pop),
      .wdata   (wdata),
      .rdata   (rdata),
      .fill    (fill),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_int;
   assign fill_level = fill;
   assign overflow   = overflow_q;

endmodule
